n_to_one_reg_mux: RTL and testbench
===================================

Name: n_to_one_reg_mux

Overview:
Parametrised N-input, W-bit registered multiplexer for the PE operand path. It is the successor to the fixed 8-bit 2:1 gate-level mux. It selects one of N valid/ready input channels, either by an explicit select or by round-robin arbitration. The selected word is registered into a one-entry output stage with valid/ready backpressure and the channel index is tagged. It sits between the operand sources and the PE datapath.

Parameters:
W, 8, data width per channel (>=1)
N, 4, number of input channels (>=2)
SW, $clog2(N), select/index width (localparam, derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
s  input  SW  channel select, used when mode=0
mode  input  1  0 = fixed select by s, 1 = round-robin
out  output  W  registered output word
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts
out_ch  output  SW  source channel of the word in out

Behaviour:
- Reset, asynchronous on rst_n low: out=0, out_valid=0, out_ch=0, rr_ptr=0. A held word is discarded. No in_ready asserted while reset is active.
- can_load = !out_valid || out_ready. A drain and a load in the same cycle are allowed, giving full throughput of one word per cycle.
- Fixed mode (mode=0): gnt = s.
  - If s >= N (N not a power of 2): no grant, all in_ready=0.
  - Otherwise in_ready[s] = can_load; all other in_ready=0.
- Round-robin mode (mode=1): gnt = first i with in_valid[i], searched from rr_ptr upward with wrap N-1 -> 0.
  - in_ready[gnt] = can_load; all other in_ready=0. in_ready must not depend on in_valid of the granted channel itself.
  - On transfer, rr_ptr <= (gnt+1) mod N. If no transfer, rr_ptr holds.
  - No valid input: no grant, all in_ready=0.
- Transfer: in_valid[gnt] && in_ready[gnt]. Next edge: out <= word of gnt, out_ch <= gnt, out_valid <= 1.
- Drain without load: out_valid <= 0. out and out_ch keep their last value.
- Stall (out_valid && !out_ready): out, out_ch and out_valid stay stable, all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- s or mode changing while stalled affects only the next load. rr_ptr is preserved across mode switches.
- No ordering guarantee between channels beyond the round-robin fairness rule. In steady state every valid channel is granted within N transfers.

Optional Feature:
MUX_BYPASS_EN
- Defined: when out_valid=0 and out_ready=1, the granted word passes combinationally to out/out_ch with out_valid=1. The transfer completes in that same cycle and nothing is registered; latency is 0. All other cases behave as without the macro.
- Undefined: out is always registered, latency is always 1, and there is no combinational path from in_* to out*.

Decomposition:
- Package pe_mux_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function next_rr(ptr, valid) returning the granted index, with a found flag.
- One sub-module, pe_out_stage: a one-entry valid/ready register of width W+SW. It covers the load/drain/stall logic and reset.
- The arbiter/select logic stays in the top module.

Test Plan:
- Reset: rst_n low mid-stall, with out=0x5A and out_valid=1 -> out=0, out_valid=0, out_ch=0 immediately, without waiting for a clock edge.
- Fixed mode: N=4, s=2, in_valid=4'b0100, in_data ch2=0xA5, out_ready=1 -> next cycle out=0xA5, out_ch=2, out_valid=1. Other channels' in_ready=0.
- Round-robin: all 4 channels valid continuously with data 0x10,0x11,0x12,0x13, out_ready=1 -> outputs are 0x10,0x11,0x12,0x13,0x10 in consecutive cycles, and out_ch wraps 3->0.
- RR sparse: in_valid=4'b1001 with rr_ptr=1 -> grant ch3, then ch0, then ch3. An invalid channel is never granted.
- Backpressure: out_ready=0 for 3 cycles with the word held at 0x77 -> out stable at 0x77, all in_ready=0. On out_ready=1 a new word loads in that same cycle.
- Invalid select: N=3, mode=0, s=3, in_valid=3'b111 -> in_ready=0 on all channels, out_valid stays 0.

Source files
------------

// File: rtl/n_to_one_reg_mux_pkg.sv
// pe_mux_pkg: shared constants and the round-robin search helper for the
// PE operand multiplexer (n_to_one_reg_mux).
//   MODE_FIXED / MODE_RR : values of the mode input
//   RR_MAX_N             : largest channel count next_rr can search
//   next_rr()            : first valid channel at or after ptr, wrapping at n
package pe_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int RR_MAX_N = 64;
  localparam int RR_IDX_W = 6;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_grant_t;

  // Scan n channels starting at ptr.  The loop bound is the fixed maximum so
  // it unrolls to a static priority chain; channels at or above n are skipped.
  function automatic rr_grant_t next_rr(input int ptr,
                                        input logic [RR_MAX_N-1:0] valid,
                                        input int n);
    rr_grant_t g;
    int        c;
    g = '0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (!g.found && valid[c[RR_IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = c[RR_IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/n_to_one_reg_mux_out_stage.sv
// pe_out_stage: one-entry valid/ready holding register.
//   clk, rst_n : clock, async active-low reset (clears data and valid)
//   load       : capture d this edge (caller only asserts it when space exists)
//   d          : word to capture
//   rdy        : downstream accepts the held word
//   q, vld     : held word and its valid flag
// A load and a drain in the same cycle simply replace the word.
module pe_out_stage #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          rdy,
  output logic [DW-1:0] q,
  output logic          vld
);

  logic [DW-1:0] data_q, data_d;
  logic          vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = d;
      vld_d  = 1'b1;
    end else if (rdy) begin
      // drain only: data is kept so out/out_ch hold their last value
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;

endmodule

// File: rtl/n_to_one_reg_mux.sv
// n_to_one_reg_mux: N-input, W-bit registered multiplexer for the PE operand
// path.  Picks one valid/ready channel by explicit select (mode=0) or by
// round-robin (mode=1) and registers the word plus its channel index.
//   clk, rst_n          : clock, async active-low reset
//   in_data[N*W]        : channel i at [i*W +: W]
//   in_valid/in_ready[N]: per-channel handshake (in_ready is combinational)
//   s[SW], mode         : fixed select / arbitration mode
//   out[W], out_ch[SW]  : held word and its source channel
//   out_valid/out_ready : output handshake
// Build option MUX_BYPASS_EN: when the output register is empty and
// out_ready=1, the granted word passes straight through with zero latency.
module n_to_one_reg_mux
  import pe_mux_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [W-1:0]   out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
);

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] gnt;
  logic          gnt_ok;
  rr_grant_t     rr_g;
  logic [W-1:0]  gnt_data;
  logic          can_load;
  logic          xfer;
  logic          load;
  logic [W-1:0]  stage_data;
  logic [SW-1:0] stage_ch;
  logic          stage_vld;

  always_comb begin
    rr_g   = next_rr(32'(rr_ptr_q), RR_MAX_N'(in_valid), N);
    gnt    = '0;
    gnt_ok = 1'b0;
    if (mode == MODE_RR) begin
      gnt    = SW'(rr_g.idx);
      gnt_ok = rr_g.found;
    end else begin
      gnt    = s;
      // s can point past the last channel when N is not a power of two
      gnt_ok = (32'(s) < N);
    end
  end

  assign can_load = !stage_vld || out_ready;

  // Ready is a function of the grant and output space only; rst_n gating
  // keeps every channel unready while reset is held.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && gnt_ok && can_load && (gnt == SW'(i));
      if (gnt == SW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && mode == MODE_RR) begin
      rr_ptr_d = (gnt == SW'(N-1)) ? '0 : gnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

`ifdef MUX_BYPASS_EN
  logic bypass;
  assign bypass    = !stage_vld && out_ready && xfer;
  assign load      = xfer && !bypass;
  assign out       = bypass ? gnt_data : stage_data;
  assign out_ch    = bypass ? gnt : stage_ch;
  assign out_valid = bypass || stage_vld;
`else
  assign load      = xfer;
  assign out       = stage_data;
  assign out_ch    = stage_ch;
  assign out_valid = stage_vld;
`endif

  pe_out_stage #(.DW(W + SW)) u_out_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     ({gnt, gnt_data}),
    .rdy   (out_ready),
    .q     ({stage_ch, stage_data}),
    .vld   (stage_vld)
  );

endmodule

// File: tb/tb_n_to_one_reg_mux.sv
module tb_n_to_one_reg_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  s, out_ch;
  logic        mode, out_valid, out_ready;
  logic [7:0]  out;

  logic [23:0] d3;
  logic [2:0]  v3, r3;
  logic [1:0]  s3, och3;
  logic        mode3, ov3, ordy3;
  logic [7:0]  o3;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_vld;
  int         m_ptr;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  n_to_one_reg_mux #(.W(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .s(s), .mode(mode), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  n_to_one_reg_mux #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .s(s3), .mode(mode3), .out(o3), .out_valid(ov3),
    .out_ready(ordy3), .out_ch(och3)
  );

  // One clock of the 4-channel DUT against the bench model: check ready,
  // push the expected word on a predicted handshake, pop when the DUT
  // presents a new word.  Starts and ends at a falling edge.
  task automatic cycle();
    int         g;
    bit         ok, can, xfer, pv, pr;
    logic [3:0] er;
    logic [9:0] e;
    ok = 1'b0;
    g  = 0;
    if (mode) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          g  = c;
        end
      end
    end else begin
      g  = int'(s);
      ok = 1'b1;
    end
    can = !m_vld || out_ready;
    er  = (ok && can) ? 4'(1 << g) : 4'b0;
    #1;
    n_cmp++;
    if (in_ready !== er) begin
      n_bad++;
      $display("FAIL in_ready: got %b expected %b", in_ready, er);
    end
    xfer = ok && can && in_valid[g];
    if (xfer) begin
      sb.push_back({2'(g), in_data[g*8 +: 8]});
      if (mode) m_ptr = (g + 1) % 4;
    end
    pv = out_valid;
    pr = out_ready;
    @(posedge clk);
    #1;
    m_vld = xfer ? 1'b1 : (can ? 1'b0 : m_vld);
    n_cmp++;
    if (out_valid !== m_vld) begin
      n_bad++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_vld);
    end
    if (out_valid && (!pv || pr)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got ch=%0d data=%h expected none", out_ch, out);
      end else begin
        e = sb.pop_front();
        if ({out_ch, out} !== e) begin
          n_bad++;
          $display("FAIL word: got ch=%0d data=%h expected ch=%0d data=%h",
                   out_ch, out, e[9:8], e[7:0]);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_word: %0d expected words not produced", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = 32'h0; in_valid = 4'hF; s = 2'd0; mode = 1'b0; out_ready = 1'b1;
    d3 = 24'h0; v3 = 3'b111; s3 = 2'd0; mode3 = 1'b0; ordy3 = 1'b1;
    m_vld = 1'b0; m_ptr = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out, out_ch, out_valid} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_out: got out=%h ch=%0d v=%b expected 0/0/0", out, out_ch, out_valid);
    end
    n_cmp++;
    if (in_ready !== 4'b0 || r3 !== 3'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b/%b expected 0000/000", in_ready, r3);
    end
    rst_n = 1'b1;
    in_valid = 4'h0; v3 = 3'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    mode = 1'b0; s = 2'd2; in_valid = 4'b0100;
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (out !== 8'hA5 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fixed_sel: got out=%h ch=%0d v=%b expected a5/2/1", out, out_ch, out_valid);
    end
  endtask

  task automatic test_rr();
    mode = 1'b1; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (out !== 8'(8'h10 + i % 4) || out_ch !== 2'(i % 4)) begin
        n_bad++;
        $display("FAIL rr_seq[%0d]: got %h ch=%0d expected %h ch=%0d",
                 i, out, out_ch, 8'(8'h10 + i % 4), i % 4);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch[3] = '{3, 0, 3};
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (out_ch !== 2'(exp_ch[i])) begin
        n_bad++;
        $display("FAIL rr_sparse[%0d]: got ch=%0d expected ch=%0d", i, out_ch, exp_ch[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; s = 2'd1; in_valid = 4'b0010;
    in_data = {8'h00, 8'h00, 8'h77, 8'h00}; out_ready = 1'b1;
    cycle();
    in_data[15:8] = 8'h78; out_ready = 1'b0;
    repeat (3) begin
      cycle();
      n_cmp++;
      if (out !== 8'h77 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold: got out=%h v=%b expected 77/1", out, out_valid);
      end
    end
    out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (out !== 8'h78) begin
      n_bad++;
      $display("FAIL stall_release: got %h expected 78", out);
    end
    in_valid = 4'b0;
    cycle();
  endtask

  task automatic test_invalid_select();
    mode3 = 1'b0; s3 = 2'd3; v3 = 3'b111; d3 = 24'hCCBBAA; ordy3 = 1'b1;
    repeat (3) begin
      #1;
      n_cmp++;
      if (r3 !== 3'b000) begin
        n_bad++;
        $display("FAIL bad_sel_ready: got %b expected 000", r3);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (ov3 !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_sel_valid: got %b expected 0", ov3);
      end
      @(negedge clk);
    end
    v3 = 3'b0;
  endtask

  task automatic test_reset_mid_stall();
    mode = 1'b0; s = 2'd1; in_valid = 4'b0010;
    in_data = {8'h00, 8'h00, 8'h5A, 8'h00}; out_ready = 1'b1;
    cycle();
    in_valid = 4'b0; out_ready = 1'b0;
    cycle();
    n_cmp++;
    if (out !== 8'h5A || out_valid !== 1'b1 || out_ch !== 2'd1) begin
      n_bad++;
      $display("FAIL prestall: got out=%h ch=%0d v=%b expected 5a/1/1", out, out_ch, out_valid);
    end
    #2;
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out, out_ch, out_valid} !== 11'h0) begin
      n_bad++;
      $display("FAIL async_reset: got out=%h ch=%0d v=%b expected 0/0/0", out, out_ch, out_valid);
    end
    n_cmp++;
    if (in_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_hold_ready: got %b expected 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b0;
    m_vld = 1'b0; m_ptr = 0; sb.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_rr_sparse();
    test_backpressure();
    test_invalid_select();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
